// File: rtl/pcie_iop2_reg_responder.sv
// IoPort2 register-message responder: decodes write/read requests from the arbiter,
// drives a strobe register bus and returns read responses upstream.
module pcie_iop2_reg_responder #(
  parameter int unsigned RD_TIMEOUT   = 256,
  parameter logic [31:0] TIMEOUT_DATA = 32'hBADC0FFE
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [63:0] regi_tdata,
  input  logic        regi_tvalid,
  output logic        regi_tready,
  output logic [63:0] rego_tdata,
  output logic        rego_tvalid,
  input  logic        rego_tready,
  output logic [19:0] reg_addr,
  output logic [31:0] reg_wr_data,
  output logic [3:0]  reg_wr_be,
  output logic        reg_wr_stb,
  output logic        reg_rd_stb,
  input  logic [31:0] reg_rd_data,
  input  logic        reg_rd_ack,
  output logic [7:0]  bad_msg_cnt,
  output logic        rd_timeout
);

  localparam int unsigned   TW   = $clog2(RD_TIMEOUT) + 1;
  localparam logic [TW-1:0] TERM = TW'(RD_TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, WRITE, READ, RD_WAIT, RESP} state_t;

  state_t          state, next_state;
  logic [TW-1:0]   timer;
  logic            hw;
  logic [31:0]     rd_data;

  logic            accept;
  logic            msg_wr;
  logic            msg_rd;
  logic            ack_taken;
  logic            timeout_hit;
  logic [31:0]     resp_data;
  logic            unused_rsvd;

  // Reserved byte of the request carries no meaning on the way in.
  assign unused_rsvd = ^regi_tdata[59:52];

  assign msg_wr = ~regi_tdata[63] &  regi_tdata[62] & ~regi_tdata[61];
  assign msg_rd = ~regi_tdata[63] & ~regi_tdata[62] &  regi_tdata[61];
  assign resp_data = hw ? {16'h0000, rd_data[15:0]} : rd_data;

  always_comb begin
    next_state  = state;
    regi_tready = 1'b0;
    reg_wr_stb  = 1'b0;
    reg_rd_stb  = 1'b0;
    rego_tvalid = 1'b0;
    rego_tdata  = '0;
    rd_timeout  = 1'b0;
    ack_taken   = 1'b0;
    timeout_hit = 1'b0;
    accept      = 1'b0;
    case (state)
      IDLE: begin
        regi_tready = 1'b1;
        accept      = regi_tvalid;
        if (regi_tvalid) begin
          if (msg_wr)      next_state = WRITE;
          else if (msg_rd) next_state = READ;
        end
      end
      WRITE: begin
        reg_wr_stb = 1'b1;
        next_state = IDLE;
      end
      READ: begin
        reg_rd_stb = 1'b1;
        ack_taken  = reg_rd_ack;
        next_state = reg_rd_ack ? RESP : RD_WAIT;
      end
      RD_WAIT: begin
        // Ack has priority over a timeout landing in the same cycle.
        if (reg_rd_ack) begin
          ack_taken  = 1'b1;
          next_state = RESP;
        end else if (timer == TERM) begin
          timeout_hit = 1'b1;
          rd_timeout  = 1'b1;
          next_state  = RESP;
        end
      end
      RESP: begin
        rego_tvalid = 1'b1;
        rego_tdata  = {1'b1, 1'b0, 1'b0, hw, 8'h00, reg_addr, resp_data};
        if (rego_tready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      timer       <= '0;
      hw          <= 1'b0;
      rd_data     <= '0;
      reg_addr    <= '0;
      reg_wr_data <= '0;
      reg_wr_be   <= '0;
      bad_msg_cnt <= '0;
    end else begin
      state <= next_state;
      if (accept) begin
        if (msg_wr || msg_rd) begin
          reg_addr    <= regi_tdata[51:32];
          reg_wr_data <= regi_tdata[31:0];
          hw          <= regi_tdata[60];
          reg_wr_be   <= regi_tdata[60] ? 4'b0011 : 4'b1111;
        end else if (bad_msg_cnt != '1) begin
          bad_msg_cnt <= bad_msg_cnt + 8'd1;
        end
      end
      if (state == READ)
        timer <= '0;
      else if (state == RD_WAIT && timer != TERM)
        timer <= timer + TW'(1);
      if (ack_taken)
        rd_data <= reg_rd_data;
      else if (timeout_hit)
        rd_data <= TIMEOUT_DATA;
    end
  end

endmodule

// File: tb/tb_pcie_iop2_reg_responder.sv
// Directed bench for pcie_iop2_reg_responder: writes, reads, timeout, malformed
// messages, back-pressure and reset during a pending response.
module tb_pcie_iop2_reg_responder;

  logic        clk;
  logic        reset_n;
  logic [63:0] regi_tdata;
  logic        regi_tvalid;
  logic        regi_tready;
  logic [63:0] rego_tdata;
  logic        rego_tvalid;
  logic        rego_tready;
  logic [19:0] reg_addr;
  logic [31:0] reg_wr_data;
  logic [3:0]  reg_wr_be;
  logic        reg_wr_stb;
  logic        reg_rd_stb;
  logic [31:0] reg_rd_data;
  logic        reg_rd_ack;
  logic [7:0]  bad_msg_cnt;
  logic        rd_timeout;

  int unsigned n_checks;
  int unsigned n_fail;

  pcie_iop2_reg_responder #(
    .RD_TIMEOUT  (16),
    .TIMEOUT_DATA(32'hBADC0FFE)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .regi_tdata (regi_tdata),
    .regi_tvalid(regi_tvalid),
    .regi_tready(regi_tready),
    .rego_tdata (rego_tdata),
    .rego_tvalid(rego_tvalid),
    .rego_tready(rego_tready),
    .reg_addr   (reg_addr),
    .reg_wr_data(reg_wr_data),
    .reg_wr_be  (reg_wr_be),
    .reg_wr_stb (reg_wr_stb),
    .reg_rd_stb (reg_rd_stb),
    .reg_rd_data(reg_rd_data),
    .reg_rd_ack (reg_rd_ack),
    .bad_msg_cnt(bad_msg_cnt),
    .rd_timeout (rd_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present one message for a single cycle; returns at the negedge after acceptance.
  task automatic send(input logic [63:0] msg);
    regi_tdata  = msg;
    regi_tvalid = 1'b1;
    @(negedge clk);
    regi_tvalid = 1'b0;
    regi_tdata  = '0;
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    reset_n     = 1'b0;
    regi_tdata  = '0;
    regi_tvalid = 1'b0;
    rego_tready = 1'b0;
    reg_rd_data = '0;
    reg_rd_ack  = 1'b0;
    repeat (2) @(negedge clk);

    check("rst_tready", 64'(regi_tready), 64'd1);
    check("rst_tvalid", 64'(rego_tvalid), 64'd0);
    check("rst_tdata",  rego_tdata, 64'd0);
    check("rst_stb",    64'({reg_wr_stb, reg_rd_stb, rd_timeout}), 64'd0);
    check("rst_bus",    64'({reg_addr, reg_wr_data, reg_wr_be}), 64'd0);
    check("rst_bad",    64'(bad_msg_cnt), 64'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Write, full word
    send({4'b0100, 8'h00, 20'h00010, 32'h0000DEAD});
    check("wr_stb",   64'(reg_wr_stb), 64'd1);
    check("wr_addr",  64'(reg_addr), 64'h10);
    check("wr_data",  64'(reg_wr_data), 64'hDEAD);
    check("wr_be",    64'(reg_wr_be), 64'hF);
    check("wr_tready_busy", 64'(regi_tready), 64'd0);
    check("wr_rdstb", 64'(reg_rd_stb), 64'd0);
    @(negedge clk);
    check("wr_stb_done", 64'(reg_wr_stb), 64'd0);
    check("wr_tready_back", 64'(regi_tready), 64'd1);
    check("wr_no_resp", 64'(rego_tvalid), 64'd0);

    // Half-word write byte enables
    send({4'b0101, 8'h00, 20'h00044, 32'h00001234});
    check("wrhw_be", 64'(reg_wr_be), 64'h3);
    check("wrhw_stb", 64'(reg_wr_stb), 64'd1);
    @(negedge clk);

    // Read with ack three cycles after the strobe
    send({4'b0010, 8'h00, 20'h00010, 32'h0});
    check("rd_stb", 64'(reg_rd_stb), 64'd1);
    @(negedge clk);
    check("rd_stb_once", 64'(reg_rd_stb), 64'd0);
    @(negedge clk);
    @(negedge clk);
    reg_rd_ack  = 1'b1;
    reg_rd_data = 32'h12345678;
    @(negedge clk);
    reg_rd_ack  = 1'b0;
    reg_rd_data = '0;
    check("rd_tvalid", 64'(rego_tvalid), 64'd1);
    check("rd_tdata",  rego_tdata, 64'h8000_0010_1234_5678);
    check("rd_tready_busy", 64'(regi_tready), 64'd0);
    rego_tready = 1'b1;
    @(negedge clk);
    rego_tready = 1'b0;
    check("rd_tvalid_drop", 64'(rego_tvalid), 64'd0);
    check("rd_idle", 64'(regi_tready), 64'd1);

    // Half-word read, ack in the strobe cycle
    send({4'b0011, 8'h00, 20'h00ABC, 32'h0});
    reg_rd_ack  = 1'b1;
    reg_rd_data = 32'hCAFEBABE;
    @(negedge clk);
    reg_rd_ack  = 1'b0;
    check("rdhw_tvalid", 64'(rego_tvalid), 64'd1);
    check("rdhw_tdata",  rego_tdata, 64'h9000_0ABC_0000_BABE);
    rego_tready = 1'b1;
    @(negedge clk);
    rego_tready = 1'b0;

    // Read that is never acked: pulse 16 cycles after the strobe
    send({4'b0010, 8'h00, 20'h00020, 32'h0});
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      check("to_early", 64'({rd_timeout, rego_tvalid}), 64'd0);
    end
    @(negedge clk);
    check("to_pulse", 64'(rd_timeout), 64'd1);
    @(negedge clk);
    check("to_pulse_end", 64'(rd_timeout), 64'd0);
    check("to_tdata", rego_tdata, 64'h8000_0020_BADC_0FFE);
    rego_tready = 1'b1;
    @(negedge clk);
    rego_tready = 1'b0;

    // Ack landing on the terminal count wins over the timeout
    send({4'b0010, 8'h00, 20'h00030, 32'h0});
    repeat (16) @(negedge clk);
    reg_rd_ack  = 1'b1;
    reg_rd_data = 32'h00000055;
    #1;
    check("race_no_pulse", 64'(rd_timeout), 64'd0);
    @(negedge clk);
    reg_rd_ack = 1'b0;
    check("race_tdata", rego_tdata, 64'h8000_0030_0000_0055);
    rego_tready = 1'b1;
    @(negedge clk);
    rego_tready = 1'b0;

    // Ack while idle is ignored
    reg_rd_ack  = 1'b1;
    reg_rd_data = 32'hFFFFFFFF;
    @(negedge clk);
    reg_rd_ack  = 1'b0;
    check("idle_ack", 64'({rego_tvalid, regi_tready}), 64'd1);

    // Malformed messages
    send({4'b1000, 8'h00, 20'h00001, 32'h1});
    check("bad1_cnt", 64'(bad_msg_cnt), 64'd1);
    check("bad1_tready", 64'(regi_tready), 64'd1);
    send({4'b0110, 8'h00, 20'h00002, 32'h2});
    check("bad2_cnt", 64'(bad_msg_cnt), 64'd2);
    check("bad2_tready", 64'(regi_tready), 64'd1);
    check("bad2_no_stb", 64'({reg_wr_stb, reg_rd_stb}), 64'd0);
    check("bad_addr_kept", 64'(reg_addr), 64'h30);
    for (int i = 0; i < 260; i++) send({4'b0000, 8'h00, 20'h0, 32'h0});
    check("bad_sat", 64'(bad_msg_cnt), 64'd255);

    // Back-pressure then reset while the response is pending
    send({4'b0010, 8'h00, 20'h00077, 32'h0});
    reg_rd_ack  = 1'b1;
    reg_rd_data = 32'hA5A5A5A5;
    @(negedge clk);
    reg_rd_ack  = 1'b0;
    reg_rd_data = '0;
    for (int i = 0; i < 10; i++) begin
      check("bp_tvalid", 64'(rego_tvalid), 64'd1);
      check("bp_tdata",  rego_tdata, 64'h8000_0077_A5A5_A5A5);
      @(negedge clk);
    end
    #2 reset_n = 1'b0;
    #1;
    check("arst_tvalid", 64'(rego_tvalid), 64'd0);
    check("arst_tdata",  rego_tdata, 64'd0);
    check("arst_bad",    64'(bad_msg_cnt), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_idle", 64'({regi_tready, rego_tvalid, reg_wr_stb, reg_rd_stb}), 64'b1000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
